ldm_stm_sequencer: RTL and testbench
====================================

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter WORD_BYTES, default 4: address step per transferred register.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  request to execute the instruction on IR; sampled only in IDLE.
REQ-005 IR  in  32  instruction word; P=IR[24], U=IR[23], W=IR[21], L=IR[20], Rn=IR[19:16], list=IR[15:0].
REQ-006 BASE  in  32  current value of Rn, sampled with START.
REQ-007 MOC  in  1  memory operation complete, from memory.
REQ-008 BUSY  out  1  high in every state except IDLE.
REQ-009 MEM_EN  out  1  memory request active.
REQ-010 MEM_RW  out  1  1=read (load), 0=write (store); equals latched L.
REQ-011 MEM_ADDR  out  32  address of the current transfer.
REQ-012 REG_NUM  out  4  register number of the current transfer.
REQ-013 REG_WE  out  1  one-cycle strobe: write loaded data to REG_NUM.
REQ-014 WB_EN  out  1  one-cycle strobe: write WB_VAL to Rn.
REQ-015 WB_VAL  out  32  final base value for writeback.
REQ-016 DONE  out  1  one-cycle completion pulse.
REQ-017 ERR  out  1  one-cycle pulse, coincident with DONE, when the register list is empty.

Function
REQ-018 States SHALL be IDLE, SETUP, REQ, WAIT, NEXT, WB, FIN; encoding is free.
REQ-019 IDLE: START=1 with IR[27:25]=3'b100 latches IR, BASE and list -> SETUP; any other IR, or START=0, stays in IDLE with no output activity.
REQ-020 START outside IDLE SHALL be ignored, with no effect on the latched instruction.
REQ-021 SETUP: N=popcount(list); start address IA=BASE, IB=BASE+4, DA=BASE-4N+4, DB=BASE-4N (4=WORD_BYTES).
REQ-022 SETUP: WB_VAL=BASE+4N if U=1, else BASE-4N; arithmetic is modulo 2^32, with no alignment check.
REQ-023 SETUP with N=0 -> FIN with ERR=1; no MEM_EN, REG_WE or WB_EN is ever asserted.
REQ-024 Transfer order: ascending register number at ascending address, for all four modes.
REQ-025 REQ: MEM_EN=1, MEM_ADDR=current address, REG_NUM=lowest remaining set bit of the list -> WAIT.
REQ-026 WAIT: MEM_EN, MEM_ADDR and REG_NUM are held stable; the FSM stays in WAIT while MOC=0; MOC=1 -> NEXT.
REQ-027 NEXT: MEM_EN=0; REG_WE=1 only if L=1; clear the serviced bit and add WORD_BYTES to the address.
REQ-028 From NEXT: remaining list nonzero -> REQ; otherwise W=1 -> WB, else -> FIN.
REQ-029 WB: WB_EN=1 for one cycle, except when L=1 and Rn is in the list; loaded data wins and WB_EN stays 0. Then -> FIN.
REQ-030 FIN: DONE=1 for one cycle -> IDLE; a START in that IDLE cycle is accepted, giving back-to-back operation.
REQ-031 Latency with MOC=1 on the first WAIT cycle: DONE is in cycle 2+3N+W after the START sampling edge.
REQ-032 Each cycle of MOC=0 in WAIT adds exactly one cycle of latency.
REQ-033 MOC outside WAIT SHALL be ignored.
REQ-034 N=16 SHALL be supported; the address counter and the remaining-list logic do not overflow.

Reset
REQ-035 RESET=1 SHALL immediately force IDLE and clear all internal registers, whether or not a clock edge occurs.
REQ-036 During reset all outputs SHALL be 0: BUSY, MEM_EN, MEM_RW, REG_WE, WB_EN, DONE, ERR low; MEM_ADDR, REG_NUM, WB_VAL zero.
REQ-037 Reset mid-transfer SHALL abort the instruction with no DONE pulse.
REQ-038 After RESET deasserts, the first START SHALL be accepted normally.

Verification
REQ-039 LDMIA R10!,{R2,R5,R7,R13}: IR=0xE8BA20A4, BASE=0x1000, MOC=1 -> addresses 0x1000/1004/1008/100C, REG_NUM 2/5/7/13, four REG_WE, WB_VAL=0x1010 with WB_EN, DONE at cycle 15.
REQ-040 STMDB R13!,{R0,R1}: IR=0xE92D0003, BASE=0x2000 -> MEM_RW=0, addresses 0x1FF8/0x1FFC, no REG_WE, WB_VAL=0x1FF8, DONE at cycle 9.
REQ-041 LDMIB R1,{R3}, no writeback: IR=0xE9910008, BASE=0x100, MOC low for 3 WAIT cycles -> MEM_ADDR=0x104 held stable, REG_NUM=3, no WB_EN, DONE at cycle 8.
REQ-042 Empty list: IR=0xE8900000 -> ERR and DONE in cycle 2, no MEM_EN.
REQ-043 Load with base in list: IR=0xE8B10006, BASE=0x40 -> REG_WE for R1 and R2, WB_EN never asserted, DONE at cycle 9.
REQ-044 RESET pulsed while in WAIT of the second transfer -> outputs 0 at once, no DONE; a following START of 0xE8BA20A4 completes as in REQ-039.

Source files
------------

// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle between the block-transfer sequencer and its controller.
// Signal suffixes are from the sequencer's point of view.
interface ldm_stm_sequencer_if;
    logic        start_i;
    logic [31:0] ir_i;
    logic [31:0] base_i;
    logic        moc_i;
    logic        busy_o;
    logic        mem_en_o;
    logic        mem_rw_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  reg_num_o;
    logic        reg_we_o;
    logic        wb_en_o;
    logic [31:0] wb_val_o;
    logic        done_o;
    logic        err_o;

    modport slave (
        input  start_i, ir_i, base_i, moc_i,
        output busy_o, mem_en_o, mem_rw_o, mem_addr_o, reg_num_o,
               reg_we_o, wb_en_o, wb_val_o, done_o, err_o
    );

    modport master (
        output start_i, ir_i, base_i, moc_i,
        input  busy_o, mem_en_o, mem_rw_o, mem_addr_o, reg_num_o,
               reg_we_o, wb_en_o, wb_val_o, done_o, err_o
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first at
// ascending addresses, handshakes each word with MOC, then optionally writes back Rn.
module ldm_stm_sequencer #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ldm_stm_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_WB,
        S_FIN
    } state_e;

    localparam logic [31:0] STEP = 32'(WORD_BYTES);

    state_e      state_q, state_d;
    logic        p_q, p_d;
    logic        u_q, u_d;
    logic        w_q, w_d;
    logic        l_q, l_d;
    logic [3:0]  rn_q, rn_d;
    logic [15:0] list_q, list_d;
    logic [31:0] base_q, base_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic        err_q, err_d;
    logic        wb_sup_q, wb_sup_d;

    logic        is_block;
    logic        unused_ir;
    logic [4:0]  n_regs;
    logic [3:0]  low_idx;
    logic [15:0] low_bit;
    logic [15:0] list_rest;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic        in_xfer;
    logic        mem_en, reg_we, wb_en, done, err;

    assign is_block  = (bus.ir_i[27:25] == 3'b100);
    assign unused_ir = ^{bus.ir_i[31:28], bus.ir_i[22]};

    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + {4'd0, list_q[i]};
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Isolate and drop the lowest set bit; the list is only consumed leaving NEXT,
    // so REG_NUM stays valid through REQ, WAIT and NEXT of the same transfer.
    assign low_bit   = list_q & (~list_q + 16'd1);
    assign list_rest = list_q & ~low_bit;

    assign span = 32'(n_regs) * STEP;

    // Lowest address of the block; the walk is always upward from here.
    always_comb begin
        unique case ({p_q, u_q})
            2'b01:   start_addr = base_q;
            2'b11:   start_addr = base_q + STEP;
            2'b00:   start_addr = base_q - span + STEP;
            default: start_addr = base_q - span;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        u_d      = u_q;
        w_d      = w_q;
        l_d      = l_q;
        rn_d     = rn_q;
        list_d   = list_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wb_val_d = wb_val_q;
        err_d    = err_q;
        wb_sup_d = wb_sup_q;
        mem_en   = 1'b0;
        reg_we   = 1'b0;
        wb_en    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && is_block) begin
                    p_d     = bus.ir_i[24];
                    u_d     = bus.ir_i[23];
                    w_d     = bus.ir_i[21];
                    l_d     = bus.ir_i[20];
                    rn_d    = bus.ir_i[19:16];
                    list_d  = bus.ir_i[15:0];
                    base_d  = bus.base_i;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                addr_d   = start_addr;
                wb_val_d = u_q ? (base_q + span) : (base_q - span);
                // A load that includes the base register keeps the loaded value.
                wb_sup_d = l_q && list_q[rn_q];
                if (n_regs == 5'd0) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_en  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                mem_en = 1'b1;
                if (bus.moc_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                reg_we = l_q;
                list_d = list_rest;
                addr_d = addr_q + STEP;
                if (list_rest != 16'd0) begin
                    state_d = S_REQ;
                end else if (w_q) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_WB: begin
                wb_en   = ~wb_sup_q;
                state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            p_q      <= 1'b0;
            u_q      <= 1'b0;
            w_q      <= 1'b0;
            l_q      <= 1'b0;
            rn_q     <= '0;
            list_q   <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            wb_val_q <= '0;
            err_q    <= 1'b0;
            wb_sup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            u_q      <= u_d;
            w_q      <= w_d;
            l_q      <= l_d;
            rn_q     <= rn_d;
            list_q   <= list_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wb_val_q <= wb_val_d;
            err_q    <= err_d;
            wb_sup_q <= wb_sup_d;
        end
    end

    assign in_xfer = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_NEXT);

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.mem_en_o   = mem_en;
    assign bus.mem_rw_o   = l_q;
    assign bus.mem_addr_o = in_xfer ? addr_q : 32'd0;
    assign bus.reg_num_o  = in_xfer ? low_idx : 4'd0;
    assign bus.reg_we_o   = reg_we;
    assign bus.wb_en_o    = wb_en;
    assign bus.wb_val_o   = wb_val_q;
    assign bus.done_o     = done;
    assign bus.err_o      = err;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: runs hand-computed LDM/STM cases and
// checks every transfer, strobe and completion cycle with immediate assertions.
module tb_ldm_stm_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ldm_stm_sequencer_if bus_if ();

    ldm_stm_sequencer #(.WORD_BYTES(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in the next IDLE cycle and checks it against
    // the expected register mask, lowest address, strobes and DONE cycle.
    task automatic run_op(
        input string       tag,
        input logic [31:0] ir,
        input logic [31:0] base,
        input int          stall_from,
        input int          stall_to,
        input bit          hold_start,
        input logic [15:0] exp_mask,
        input logic [31:0] exp_addr0,
        input logic        exp_rw,
        input bit          exp_we,
        input bit          exp_wb,
        input logic [31:0] exp_wb_val,
        input int          exp_done,
        input bit          exp_err
    );
        logic [31:0] rec_addr [16];
        logic [3:0]  rec_reg  [16];
        logic [31:0] wb_seen;
        logic        prev_en;
        int nx, unstable, rw_bad, we_cnt, we_bad, wb_cnt, err_cnt, done_cyc, err_at_done;
        int exp_n, k;

        nx = 0; unstable = 0; rw_bad = 0; we_cnt = 0; we_bad = 0; wb_cnt = 0;
        err_cnt = 0; done_cyc = 0; err_at_done = 0; prev_en = 1'b0; wb_seen = '0;

        @(negedge clk);
        chk({tag, ".idle_busy"}, {31'd0, bus_if.busy_o}, 32'd0);
        bus_if.start_i = 1'b1;
        bus_if.ir_i    = ir;
        bus_if.base_i  = base;
        bus_if.moc_i   = 1'b1;
        @(posedge clk);
        #1;
        if (hold_start) begin
            bus_if.ir_i   = 32'hE890_0000;
            bus_if.base_i = 32'hDEAD_0000;
        end else begin
            bus_if.start_i = 1'b0;
        end

        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            bus_if.moc_i = (cyc >= stall_from && cyc < stall_to) ? 1'b0 : 1'b1;
            if (bus_if.mem_en_o) begin
                if (!prev_en) begin
                    if (nx < 16) begin
                        rec_addr[nx] = bus_if.mem_addr_o;
                        rec_reg[nx]  = bus_if.reg_num_o;
                    end
                    nx++;
                end else if (nx >= 1 && nx <= 16) begin
                    if (bus_if.mem_addr_o !== rec_addr[nx-1] || bus_if.reg_num_o !== rec_reg[nx-1])
                        unstable++;
                end
                if (bus_if.mem_rw_o !== exp_rw) rw_bad++;
            end
            prev_en = bus_if.mem_en_o;
            if (bus_if.reg_we_o) begin
                we_cnt++;
                if (nx < 1 || nx > 16) we_bad++;
                else if (bus_if.reg_num_o !== rec_reg[nx-1]) we_bad++;
            end
            if (bus_if.wb_en_o) begin
                wb_cnt++;
                wb_seen = bus_if.wb_val_o;
            end
            if (bus_if.err_o) err_cnt++;
            if (bus_if.done_o) begin
                done_cyc    = cyc;
                err_at_done = int'(bus_if.err_o);
                bus_if.start_i = 1'b0;
                bus_if.moc_i   = 1'b1;
                break;
            end
        end
        bus_if.start_i = 1'b0;

        exp_n = 0;
        for (int r = 0; r < 16; r++) if (exp_mask[r]) exp_n++;

        chk({tag, ".n_xfers"}, 32'(nx), 32'(exp_n));
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (exp_mask[r]) begin
                if (k < nx && k < 16) begin
                    chk($sformatf("%s.addr%0d", tag, k), rec_addr[k], exp_addr0 + 32'(4 * k));
                    chk($sformatf("%s.reg%0d", tag, k), {28'd0, rec_reg[k]}, 32'(r));
                end
                k++;
            end
        end
        chk({tag, ".held_stable"}, 32'(unstable), 32'd0);
        chk({tag, ".mem_rw"}, 32'(rw_bad), 32'd0);
        chk({tag, ".reg_we_cnt"}, 32'(we_cnt), exp_we ? 32'(exp_n) : 32'd0);
        chk({tag, ".reg_we_num"}, 32'(we_bad), 32'd0);
        chk({tag, ".wb_en_cnt"}, 32'(wb_cnt), exp_wb ? 32'd1 : 32'd0);
        if (exp_wb) chk({tag, ".wb_val"}, wb_seen, exp_wb_val);
        chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, ".err_at_done"}, 32'(err_at_done), exp_err ? 32'd1 : 32'd0);
        chk({tag, ".err_cycles"}, 32'(err_cnt), exp_err ? 32'd1 : 32'd0);
        $display("op %-10s ir=%08h base=%08h xfers=%0d done_cycle=%0d", tag, ir, base, nx, done_cyc);
    endtask

    function automatic logic [31:0] all_outputs();
        return {bus_if.busy_o, bus_if.mem_en_o, bus_if.mem_rw_o, bus_if.reg_we_o,
                bus_if.wb_en_o, bus_if.done_o, bus_if.err_o, 25'd0}
             | bus_if.mem_addr_o | {28'd0, bus_if.reg_num_o} | bus_if.wb_val_o;
    endfunction

    initial begin
        int act;
        int dones;

        bus_if.start_i = 1'b0;
        bus_if.ir_i    = '0;
        bus_if.base_i  = '0;
        bus_if.moc_i   = 1'b1;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1 chk("reset.outputs", all_outputs(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LDMIA R10!,{R2,R5,R7,R13}
        run_op("ldmia_wb", 32'hE8BA_20A4, 32'h0000_1000, 0, 0, 1'b0,
               16'h20A4, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 32'h0000_1010, 15, 1'b0);
        // STMDB R13!,{R0,R1}, START held high with another instruction while busy
        run_op("stmdb_wb", 32'hE92D_0003, 32'h0000_2000, 0, 0, 1'b1,
               16'h0003, 32'h0000_1FF8, 1'b0, 1'b0, 1'b1, 32'h0000_1FF8, 9, 1'b0);
        // LDMIB R1,{R3} with MOC low for three WAIT cycles
        run_op("ldmib_stl", 32'hE991_0008, 32'h0000_0100, 3, 6, 1'b0,
               16'h0008, 32'h0000_0104, 1'b1, 1'b1, 1'b0, 32'h0, 8, 1'b0);
        // Empty list
        run_op("empty", 32'hE890_0000, 32'h0000_0300, 0, 0, 1'b0,
               16'h0000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2, 1'b1);
        // Load with base in list: no writeback
        run_op("ld_base", 32'hE8B1_0006, 32'h0000_0040, 0, 0, 1'b0,
               16'h0006, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 32'h0, 9, 1'b0);
        // LDMDA R4!,{R4,R5}: base in list again, lowest address BASE-4
        run_op("ldmda", 32'hE834_0030, 32'h0000_0500, 0, 0, 1'b0,
               16'h0030, 32'h0000_04FC, 1'b1, 1'b1, 1'b0, 32'h0, 9, 1'b0);
        // STMDA R4!,{R0,R5}: writeback below base
        run_op("stmda", 32'hE824_0021, 32'h0000_0500, 0, 0, 1'b0,
               16'h0021, 32'h0000_04FC, 1'b0, 1'b0, 1'b1, 32'h0000_04F8, 9, 1'b0);

        // Non block-transfer instruction: no activity
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.ir_i    = 32'hE591_2000;
        act = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            act += int'(bus_if.busy_o | bus_if.mem_en_o | bus_if.reg_we_o |
                        bus_if.wb_en_o | bus_if.done_o | bus_if.err_o);
        end
        bus_if.start_i = 1'b0;
        chk("non_ldm.activity", 32'(act), 32'd0);

        // STMIA R0!,{R0-R15} with address wrap past 2^32
        run_op("stm16", 32'hE8A0_FFFF, 32'hFFFF_FFC0, 0, 0, 1'b0,
               16'hFFFF, 32'hFFFF_FFC0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 51, 1'b0);

        // Reset while in WAIT of the second transfer
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.ir_i    = 32'hE8BA_20A4;
        bus_if.base_i  = 32'h0000_1000;
        bus_if.moc_i   = 1'b1;
        @(posedge clk);
        #1 bus_if.start_i = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            bus_if.moc_i = (cyc >= 6) ? 1'b0 : 1'b1;
        end
        chk("abort.mem_en", {31'd0, bus_if.mem_en_o}, 32'd1);
        chk("abort.addr", bus_if.mem_addr_o, 32'h0000_1004);
        #2 rst = 1'b1;
        #1 chk("abort.outputs", all_outputs(), 32'd0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            dones += int'(bus_if.done_o);
        end
        rst = 1'b0;
        bus_if.moc_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            dones += int'(bus_if.done_o);
        end
        chk("abort.no_done", 32'(dones), 32'd0);
        $display("op %-10s ir=%08h aborted by reset", "abort", 32'hE8BA_20A4);

        run_op("after_rst", 32'hE8BA_20A4, 32'h0000_1000, 0, 0, 1'b0,
               16'h20A4, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 32'h0000_1010, 15, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
